// File: rtl/debounce_sync.sv
// Synchronises a raw async level into clk and debounces it; optional o_toggle under DEBOUNCE_TOGGLE_EN.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from first sample to o_value change; pulses registered.
// Backpressure: none, free-running level conditioner with no handshake.
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic async_reset_n,
    input  logic i_value,
    output logic o_value,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic o_toggle
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        COUNT_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        COUNT_LOW   = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sync_q   <= '0;
            state    <= STABLE_LOW;
            cnt      <= '0;
            o_value  <= 1'b0;
            o_rise   <= 1'b0;
            o_fall   <= 1'b0;
            o_busy   <= 1'b0;
`ifdef DEBOUNCE_TOGGLE_EN
            o_toggle <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_value};
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        state  <= COUNT_HIGH;
                        cnt    <= CNT_ONE;
                        o_busy <= 1'b1;
                    end else begin
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end
                end
                COUNT_HIGH: begin
                    if (!s) begin
                        // Run broke before completing: drop it, next run restarts at 1.
                        state  <= STABLE_LOW;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= STABLE_HIGH;
                        cnt      <= '0;
                        o_value  <= 1'b1;
                        o_rise   <= 1'b1;
                        o_busy   <= 1'b0;
`ifdef DEBOUNCE_TOGGLE_EN
                        o_toggle <= ~o_toggle;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state  <= COUNT_LOW;
                        cnt    <= CNT_ONE;
                        o_busy <= 1'b1;
                    end else begin
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end
                end
                COUNT_LOW: begin
                    if (s) begin
                        state  <= STABLE_HIGH;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= STABLE_LOW;
                        cnt     <= '0;
                        o_value <= 1'b0;
                        o_fall  <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= STABLE_LOW;
                    cnt     <= '0;
                    o_value <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
